// File: rtl/blk_check_arbiter.sv
// blk_check_arbiter: lends one shared begin/end checker to N_REQ character streams, one whole frame at a time.
// Build option: define BLKARB_ROUND_ROBIN_EN for round-robin arbitration; left undefined, lowest index wins.
module blk_check_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MAX_LEN = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     in_valid,
    input  logic [8*N_REQ-1:0]   in_data,
    input  logic [N_REQ-1:0]     in_last,
    output logic [N_REQ-1:0]     in_ready,
    output logic [N_REQ-1:0]     resp_done,
    output logic                 resp_result,
    output logic                 resp_err,
    output logic                 chk_clr,
    output logic                 chk_en,
    output logic [7:0]           chk_in,
    input  logic                 chk_result,
    output logic [2:0]           dbg_state
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int GW = $clog2(N_REQ);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]    r_state;
    logic [GW-1:0] r_gnt;
    logic [LW-1:0] r_len;
    logic          r_err;
    logic          r_resp;

    logic [GW-1:0] w_win;
    logic          w_any;
    logic          w_sel_valid;
    logic          w_sel_last;
    logic [7:0]    w_sel_data;
    logic          w_xfer;
    logic          w_full;

`ifdef BLKARB_ROUND_ROBIN_EN
    logic [GW-1:0] r_ptr;
`endif

    assign w_any = |in_valid;

    // Winner search starts at the base index and wraps once around all requesters.
    always_comb begin
        int base;
        int j;
`ifdef BLKARB_ROUND_ROBIN_EN
        base = int'(r_ptr);
`else
        base = 0;
`endif
        w_win = '0;
        j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = base + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (in_valid[j]) begin
                w_win = GW'(j);
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_gnt == GW'(i)) begin
                w_sel_valid = in_valid[i];
                w_sel_last  = in_last[i];
                w_sel_data  = in_data[8*i +: 8];
            end
        end
    end

    // Handshake: a character moves on a rising edge where in_valid[i] and in_ready[i] are both high;
    // in_ready depends only on registered state, so a requester may hold or drop in_valid freely.
    assign w_xfer = (r_state == S_STREAM) && w_sel_valid;
    assign w_full = (r_len == LW'(MAX_LEN));

    always_comb begin
        in_ready  = '0;
        resp_done = '0;
        for (int i = 0; i < N_REQ; i++) begin
            in_ready[i]  = (r_state == S_STREAM) && (r_gnt == GW'(i));
            resp_done[i] = (r_state == S_RESP) && (r_gnt == GW'(i));
        end
    end

    assign chk_clr     = (r_state == S_CLR);
    assign chk_en      = w_xfer && !w_full;
    assign chk_in      = chk_en ? w_sel_data : 8'h00;
    assign resp_result = (r_state == S_RESP) && r_resp;
    assign resp_err    = (r_state == S_RESP) && r_err;
    assign dbg_state   = r_state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_len   <= '0;
            r_err   <= 1'b0;
            r_resp  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_win;
                        r_state <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_len   <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        // Characters past MAX_LEN never reach the checker; the frame is only flagged.
                        if (w_full) begin
                            r_err <= 1'b1;
                        end else begin
                            r_len <= r_len + LW'(1);
                        end
                        if (w_sel_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_resp  <= chk_result;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BLKARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (r_state == S_RESP) begin
            r_ptr <= (r_gnt == GW'(N_REQ - 1)) ? '0 : r_gnt + GW'(1);
        end
    end
`endif

endmodule
